// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ valid/ready producers,
// with write-ack checking. Define FIFO_ARB_STATS_EN to add saturating per-requester grant counters.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int FIFO_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          arb_en,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [FIFO_WIDTH-1:0]         fifo_data_in,
  output logic                          fifo_wr_en,
  input  logic                          fifo_full,
  input  logic                          fifo_almostfull,
  input  logic                          fifo_wr_ack,
  input  logic                          fifo_overflow,
  output logic                          wr_err
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [NUM_REQ*CNT_WIDTH-1:0]  grant_cnt
`endif
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [IDX_W-1:0] last_winner;
  logic [IDX_W-1:0] win_idx_p0;
  logic             vld_p0;
  logic             can_issue;
  logic             ack_pending;
  logic             chk_en;
  int               idx;

  // A write in flight while almostfull would fill the FIFO, so hold off the next one.
  assign can_issue = arb_en & ~fifo_full & ~(fifo_wr_en & fifo_almostfull);

  // Stage p0: combinational round-robin search starting after the last winner
  always_comb begin
    gnt        = '0;
    win_idx_p0 = last_winner;
    vld_p0     = 1'b0;
    idx        = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_winner) + k) % NUM_REQ;
      if (can_issue && !vld_p0 && req[idx]) begin
        vld_p0     = 1'b1;
        win_idx_p0 = IDX_W'(idx);
      end
    end
    if (vld_p0) gnt[win_idx_p0] = 1'b1;
  end

  // Stage p1: registered write to the FIFO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_wr_en   <= 1'b0;
      fifo_data_in <= '0;
      last_winner  <= IDX_W'(NUM_REQ - 1);
    end else begin
      fifo_wr_en <= vld_p0;
      if (vld_p0) begin
        fifo_data_in <= req_data[int'(win_idx_p0)*FIFO_WIDTH +: FIFO_WIDTH];
        last_winner  <= win_idx_p0;
      end
    end
  end

  // Stage p2: the FIFO acks one cycle after each write; chk_en masks the first cycle out of reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_pending <= 1'b0;
      chk_en      <= 1'b0;
      wr_err      <= 1'b0;
    end else begin
      ack_pending <= fifo_wr_en;
      chk_en      <= 1'b1;
      if (chk_en && ((fifo_wr_ack != ack_pending) || fifo_overflow)) wr_err <= 1'b1;
    end
  end

`ifdef FIFO_ARB_STATS_EN
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (gnt[i] && req[i])
          grant_cnt[i*CNT_WIDTH +: CNT_WIDTH] <= sat_inc(grant_cnt[i*CNT_WIDTH +: CNT_WIDTH]);
      end
    end
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter driving a depth-8 FIFO model on its write port.
module tb_fifo_wr_arbiter;

  localparam int NUM_REQ = 4;
  localparam int W       = 16;
  localparam int DEPTH   = 8;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 arb_en;
  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ*W-1:0] req_data;
  logic [NUM_REQ-1:0]   gnt;
  logic [W-1:0]         fifo_data_in;
  logic                 fifo_wr_en;
  logic                 fifo_full;
  logic                 fifo_almostfull;
  logic                 fifo_wr_ack;
  logic                 fifo_overflow;
  logic                 wr_err;
`ifdef FIFO_ARB_STATS_EN
  logic [NUM_REQ*16-1:0] grant_cnt;
`endif

  // FIFO model state
  int   count;
  logic rd_en;
  logic ack_kill;
  logic wr_ack_r;
  logic ovf_r;
  logic ovf_seen;

  int n_checks = 0;
  int n_errors = 0;
  int nwr;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.NUM_REQ(NUM_REQ), .FIFO_WIDTH(W), .CNT_WIDTH(16)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .arb_en          (arb_en),
    .req             (req),
    .req_data        (req_data),
    .gnt             (gnt),
    .fifo_data_in    (fifo_data_in),
    .fifo_wr_en      (fifo_wr_en),
    .fifo_full       (fifo_full),
    .fifo_almostfull (fifo_almostfull),
    .fifo_wr_ack     (fifo_wr_ack),
    .fifo_overflow   (fifo_overflow),
    .wr_err          (wr_err)
`ifdef FIFO_ARB_STATS_EN
    ,
    .grant_cnt       (grant_cnt)
`endif
  );

  assign fifo_full       = (count == DEPTH);
  assign fifo_almostfull = (count == DEPTH - 1);
  assign fifo_wr_ack     = wr_ack_r & ~ack_kill;
  assign fifo_overflow   = ovf_r;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= 0;
      wr_ack_r <= 1'b0;
      ovf_r    <= 1'b0;
      ovf_seen <= 1'b0;
    end else begin
      count    <= count + ((fifo_wr_en && count < DEPTH) ? 1 : 0) - ((rd_en && count > 0) ? 1 : 0);
      wr_ack_r <= fifo_wr_en && (count < DEPTH);
      ovf_r    <= fifo_wr_en && (count == DEPTH);
      if (fifo_wr_en && count == DEPTH) ovf_seen <= 1'b1;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n    = 1'b0;
    arb_en   = 1'b1;
    req      = '0;
    req_data = '0;
    rd_en    = 1'b0;
    ack_kill = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_gnt", gnt, 4'b0000);
    check("rst_wr_en", fifo_wr_en, 1'b0);
    check("rst_data", fifo_data_in, 16'h0000);
    check("rst_wr_err", wr_err, 1'b0);
    rst_n = 1'b1;

    // Single requester streams 5 beats
    for (int b = 0; b < 5; b++) begin
      req = 4'b0001;
      req_data[W-1:0] = 16'hA000 + W'(b);
      #1;
      check("s1_gnt", gnt, 4'b0001);
      tick();
      check("s1_wr_en", fifo_wr_en, 1'b1);
      check("s1_data", fifo_data_in, 16'hA000 + 16'(b));
      check("s1_ack", fifo_wr_ack, (b > 0) ? 1'b1 : 1'b0);
    end
    req = '0;
    #1;
    check("s1_gnt_idle", gnt, 4'b0000);
    tick();
    check("s1_wr_en_off", fifo_wr_en, 1'b0);
    check("s1_ack_last", fifo_wr_ack, 1'b1);
    tick();
    check("s1_ack_off", fifo_wr_ack, 1'b0);
    check("s1_count", count, 5);
    check("s1_wr_err", wr_err, 1'b0);

    // All requesters, FIFO drained every cycle
    reset_pulse();
    rd_en    = 1'b1;
    req_data = {16'hB003, 16'hB002, 16'hB001, 16'hB000};
    req      = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("rr_gnt", gnt, 4'b0001 << (k % 4));
      tick();
      check("rr_data", fifo_data_in, 16'hB000 + 16'(k % 4));
    end
    check("rr_wr_err", wr_err, 1'b0);

    // Fill a depth-8 FIFO with no reads from requester 2
    req = '0;
    reset_pulse();
    rd_en = 1'b0;
    req   = 4'b0100;
    nwr   = 0;
    for (int c = 0; c < 12; c++) begin
      #1;
      check("fill_gnt", gnt, (c < 8) ? 4'b0100 : 4'b0000);
      if (count == DEPTH - 1 && fifo_wr_en) check("fill_af_block", gnt, 4'b0000);
      if (gnt[2]) nwr++;
      tick();
    end
    check("fill_grants", nwr, 8);
    check("fill_count", count, 8);
    check("fill_ovf", ovf_seen, 1'b0);
    check("fill_wr_err", wr_err, 1'b0);

    // Full, then one read frees a single slot
    #1;
    check("full_gnt", gnt, 4'b0000);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    #1;
    check("rd1_count", count, 7);
    check("rd1_gnt", gnt, 4'b0100);
    tick();
    check("rd1_wr_en", fifo_wr_en, 1'b1);
    #1;
    check("rd1_block", gnt, 4'b0000);
    tick();
    check("rd1_count_full", count, 8);
    check("rd1_gnt_full", gnt, 4'b0000);
    check("rd1_ovf", ovf_seen, 1'b0);
    check("rd1_wr_err", wr_err, 1'b0);

    // arb_en low for 3 cycles
    req = '0;
    reset_pulse();
    rd_en    = 1'b1;
    req_data = {16'hB003, 16'hB002, 16'hB001, 16'hB000};
    req      = 4'b1111;
    #1;
    check("en_gnt0", gnt, 4'b0001);
    tick();
    #1;
    check("en_gnt1", gnt, 4'b0010);
    tick();
    arb_en = 1'b0;
    #1;
    check("en_inflight_wr", fifo_wr_en, 1'b1);
    check("en_inflight_data", fifo_data_in, 16'hB001);
    for (int c = 0; c < 3; c++) begin
      #1;
      check("en_off_gnt", gnt, 4'b0000);
      tick();
      check("en_off_wr_en", fifo_wr_en, 1'b0);
    end
    arb_en = 1'b1;
    #1;
    check("en_resume2", gnt, 4'b0100);
    tick();
    #1;
    check("en_resume3", gnt, 4'b1000);
    tick();
`ifdef FIFO_ARB_STATS_EN
    check("stats_cnt", grant_cnt, {16'd1, 16'd1, 16'd1, 16'd1});
`endif

    // Missing write acknowledge sets sticky wr_err
    req = '0;
    reset_pulse();
    req_data = {16'h0, 16'h0, 16'hD001, 16'h0};
    req      = 4'b0010;
    #1;
    check("ack_gnt", gnt, 4'b0010);
    tick();
    req      = '0;
    ack_kill = 1'b1;
    check("ack_wr_en", fifo_wr_en, 1'b1);
    tick();
    check("ack_err_before", wr_err, 1'b0);
    tick();
    check("ack_err_set", wr_err, 1'b1);
    ack_kill = 1'b0;
    repeat (3) tick();
    check("ack_err_sticky", wr_err, 1'b1);
    reset_pulse();
    #1;
    check("ack_err_cleared", wr_err, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
